hdmi_pixel_feeder: RTL and testbench

//  Replaces the test-pattern stage between sync_vg and the ADV7513 pins: sources RGB

---
 rtl/hdmi_pixel_feeder.sv | 211 +++++++++++++++++++++
 tb/tb_hdmi_pixel_feeder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pixel_feeder.sv
// hdmi_pixel_feeder
//   Sources HDMI RGB from a valid/ready pixel stream instead of a pattern
//   generator. Pixels are buffered in a small FIFO. The stream's start-of-frame
//   marker is aligned to the first active pixel of the sync_vg frame. The block
//   then emits de/hs/vs/RGB toward the ADV7513 pins.
//   Underflow and misalignment flush the FIFO, and the block relocks on a later
//   frame.
// Ports
//   clk, reset                  pixel clock, synchronous active-high reset
//   pix_data/pix_sof/pix_valid  incoming stream pixel {r,g,b}, frame marker, valid
//   pix_ready                   stream accept (transfer on pix_valid && pix_ready)
//   vs_in/hs_in/de_in/x_in/y_in timing and active-pixel coordinates from sync_vg
//   vs_out/hs_out/de_out        timing delayed one clock to line up with RGB
//   r_out/g_out/b_out           pixel colour
//   synced                      high while streaming locked to the frame
//   underflow                   sticky error flag, cleared only by reset
//   fifo_level                  current FIFO occupancy
module hdmi_pixel_feeder #(
    parameter int unsigned B          = 8,
    parameter int unsigned X_BITS     = 12,
    parameter int unsigned Y_BITS     = 12,
    parameter int unsigned ADDR_BITS  = 4,
    parameter logic [3*B-1:0] FILL_COLOR = 24'h0000FF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3*B-1:0]       pix_data,
    input  logic                 pix_sof,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 vs_in,
    input  logic                 hs_in,
    input  logic                 de_in,
    input  logic [X_BITS-1:0]    x_in,
    input  logic [Y_BITS-1:0]    y_in,
    output logic                 vs_out,
    output logic                 hs_out,
    output logic                 de_out,
    output logic [B-1:0]         r_out,
    output logic [B-1:0]         g_out,
    output logic [B-1:0]         b_out,
    output logic                 synced,
    output logic                 underflow,
    output logic [ADDR_BITS:0]   fifo_level
);

    localparam int unsigned PIX_W = 3 * B;
    localparam int unsigned LVL_W = ADDR_BITS + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    typedef struct packed {
        logic             sof;
        logic [PIX_W-1:0] data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        S_FLUSH      = 2'd0,
        S_WAIT_SOF   = 2'd1,
        S_WAIT_FRAME = 2'd2,
        S_RUN        = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    fifo_entry_t            mem [DEPTH];
    fifo_entry_t            head;
    logic [ADDR_BITS-1:0]   wr_ptr;
    logic [ADDR_BITS-1:0]   rd_ptr;
    logic                   full;
    logic                   empty;
    logic                   frame_start;
    logic                   push;
    logic                   pop;
    logic                   flush;
    logic                   set_uf;
    logic [PIX_W-1:0]       rgb_nxt;

    // FIFO status; the head is read from the registered pointer, so there is no bypass
    assign full        = (fifo_level == LVL_W'(DEPTH));
    assign empty       = (fifo_level == '0);
    assign head        = mem[rd_ptr];
    assign frame_start = de_in && (x_in == '0) && (y_in == '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, FIFO control and next pixel colour
    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        set_uf    = 1'b0;
        rgb_nxt   = de_in ? FILL_COLOR : '0;

        case (state)
            S_FLUSH: begin
                flush     = 1'b1;
                state_nxt = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                // Everything ahead of the frame marker is dropped on the floor
                pix_ready = 1'b1;
                if (pix_valid && pix_sof) begin
                    push      = 1'b1;
                    state_nxt = S_WAIT_FRAME;
                end
            end
            S_WAIT_FRAME: begin
                pix_ready = !full;
                push      = pix_valid && !full;
                // Head is the sof pixel; it lands on (0,0)
                if (frame_start) begin
                    pop       = 1'b1;
                    rgb_nxt   = head.data;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                pix_ready = !full;
                push      = pix_valid && !full;
                if (de_in) begin
                    if (empty) begin
                        set_uf    = 1'b1;
                        state_nxt = S_FLUSH;
                    end else begin
                        pop     = 1'b1;
                        rgb_nxt = head.data;
                        // Marker and frame origin must coincide exactly
                        if (head.sof != frame_start) begin
                            set_uf    = 1'b1;
                            state_nxt = S_FLUSH;
                        end
                    end
                end
            end
            default: begin
                state_nxt = S_FLUSH;
            end
        endcase

        if (reset) begin
            pix_ready = 1'b0;
            push      = 1'b0;
        end
    end

    // FIFO storage (no reset needed; validity tracked by the pointers)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {pix_sof, pix_data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (flush) begin
                rd_ptr     <= wr_ptr;
                fifo_level <= '0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + ADDR_BITS'(1);
                end
                case ({push, pop})
                    2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                    2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                    default: fifo_level <= fifo_level;
                endcase
            end
        end
    end

    // Registered video outputs and status
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_out    <= 1'b0;
            hs_out    <= 1'b0;
            de_out    <= 1'b0;
            r_out     <= '0;
            g_out     <= '0;
            b_out     <= '0;
            synced    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            vs_out    <= vs_in;
            hs_out    <= hs_in;
            de_out    <= de_in;
            r_out     <= rgb_nxt[3*B-1:2*B];
            g_out     <= rgb_nxt[2*B-1:B];
            b_out     <= rgb_nxt[B-1:0];
            synced    <= (state_nxt == S_RUN);
            underflow <= underflow | set_uf;
        end
    end

endmodule

// File: tb/tb_hdmi_pixel_feeder.sv
// Randomized bench for hdmi_pixel_feeder against a queue-based frame model.
module tb_hdmi_pixel_feeder;

    localparam int unsigned DEPTH     = 16;
    localparam logic [23:0] FILL      = 24'h0000FF;
    localparam int          H_ACT     = 32;
    localparam int          H_TOT     = 40;
    localparam int          V_ACT     = 6;
    localparam int          V_TOT     = 9;
    localparam int          FRAME_PIX = H_ACT * V_ACT;
    localparam int          FRAME_CYC = H_TOT * V_TOT;

    // Model lock phases
    localparam int M_DRAIN = 0;
    localparam int M_HUNT  = 1;
    localparam int M_ARMED = 2;
    localparam int M_LOCK  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] pix_data;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready;
    logic        vs_in, hs_in, de_in;
    logic [11:0] x_in, y_in;
    logic        vs_out, hs_out, de_out;
    logic [7:0]  r_out, g_out, b_out;
    logic        synced;
    logic        underflow;
    logic [4:0]  fifo_level;

    always #5 clk = ~clk;

    hdmi_pixel_feeder dut (
        .clk        (clk),
        .reset      (reset),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .vs_in      (vs_in),
        .hs_in      (hs_in),
        .de_in      (de_in),
        .x_in       (x_in),
        .y_in       (y_in),
        .vs_out     (vs_out),
        .hs_out     (hs_out),
        .de_out     (de_out),
        .r_out      (r_out),
        .g_out      (g_out),
        .b_out      (b_out),
        .synced     (synced),
        .underflow  (underflow),
        .fifo_level (fifo_level)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Timing generator, stream source and model state
    int          hc = 0;
    int          vc = 0;
    int          valid_pct = 100;
    int          src_idx = 0;
    logic [23:0] src_data;
    logic        src_sof;
    logic        force_next = 1'b0;
    logic [23:0] force_val;
    int          phase = M_DRAIN;
    logic [24:0] mq[$];
    logic        model_uf = 1'b0;

    task automatic src_advance();
        src_idx  = (src_idx + 1) % FRAME_PIX;
        src_sof  = (src_idx == 0);
        src_data = force_next ? force_val : 24'($urandom);
        force_next = 1'b0;
    endtask

    // Restart the source's frame at the next offered pixel
    task automatic src_inject_sof();
        src_idx  = 0;
        src_sof  = 1'b1;
        src_data = 24'($urandom);
    endtask

    // One pixel clock: drive, predict, then compare registered outputs
    task automatic tick();
        logic        exp_ready;
        logic        xfer;
        logic        fs;
        logic [23:0] exp_rgb;
        logic [24:0] h;
        int          nphase;

        @(negedge clk);
        de_in     = (hc < H_ACT) && (vc < V_ACT);
        x_in      = 12'(hc);
        y_in      = 12'(vc);
        hs_in     = (hc >= 34) && (hc < 37);
        vs_in     = (vc == 7);
        pix_valid = (int'($urandom_range(99)) < valid_pct);
        pix_data  = src_data;
        pix_sof   = src_sof;
        #1;

        if (reset) exp_ready = 1'b0;
        else if (phase == M_DRAIN) exp_ready = 1'b0;
        else if (phase == M_HUNT) exp_ready = 1'b1;
        else exp_ready = (mq.size() < DEPTH);
        check_eq("ready", 32'(pix_ready), 32'(exp_ready));

        xfer    = pix_valid && exp_ready;
        fs      = de_in && (hc == 0) && (vc == 0);
        exp_rgb = de_in ? FILL : 24'h0;
        nphase  = phase;

        if (reset) begin
            mq.delete();
            nphase   = M_DRAIN;
            model_uf = 1'b0;
        end else begin
            case (phase)
                M_DRAIN: begin
                    mq.delete();
                    nphase = M_HUNT;
                end
                M_HUNT: if (xfer && pix_sof) nphase = M_ARMED;
                M_ARMED: if (fs) begin
                    h       = mq.pop_front();
                    exp_rgb = h[23:0];
                    nphase  = M_LOCK;
                end
                default: if (de_in) begin
                    if (mq.size() == 0) begin
                        model_uf = 1'b1;
                        nphase   = M_DRAIN;
                    end else begin
                        h       = mq.pop_front();
                        exp_rgb = h[23:0];
                        if (h[24] != fs) begin
                            model_uf = 1'b1;
                            nphase   = M_DRAIN;
                        end
                    end
                end
            endcase
            if (xfer && (phase != M_HUNT || pix_sof)) mq.push_back({pix_sof, pix_data});
        end
        phase = nphase;

        @(posedge clk);
        #1;
        if (reset) begin
            check_eq("rst_tim", 32'({vs_out, hs_out, de_out}), 32'(0));
            check_eq("rst_rgb", 32'({r_out, g_out, b_out}), 32'(0));
        end else begin
            check_eq("tim", 32'({vs_out, hs_out, de_out}), 32'({vs_in, hs_in, de_in}));
            check_eq("rgb", 32'({r_out, g_out, b_out}), 32'(exp_rgb));
        end
        check_eq("synced", 32'(synced), 32'(phase == M_LOCK && !reset));
        check_eq("underflow", 32'(underflow), 32'(model_uf));
        check_eq("level", 32'(fifo_level), 32'(mq.size()));

        if (xfer) src_advance();
        hc++;
        if (hc == H_TOT) begin
            hc = 0;
            vc = (vc + 1) % V_TOT;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset     = 1'b1;
        pix_valid = 1'b1;
        pix_data  = '0;
        pix_sof   = 1'b0;
        vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
        x_in  = '0;   y_in  = '0;
        src_sof  = 1'b1;
        src_data = 24'h112233;

        // Reset held 3 clocks with valid high, timing parked in vertical blanking
        hc = 0;
        vc = V_ACT;
        run_cycles(3);
        check_eq("t1_ready", 32'(pix_ready), 32'(0));
        check_eq("t1_level", 32'(fifo_level), 32'(0));
        reset = 1'b0;

        // Directed lock: sof 0x112233 then 0x445566, FIFO fills during blanking
        src_idx    = 0;
        src_sof    = 1'b1;
        src_data   = 24'h112233;
        force_next = 1'b1;
        force_val  = 24'h445566;
        valid_pct  = 100;
        for (int n = 0; n < 2 * FRAME_CYC && !(hc == 0 && vc == 0); n++) tick();
        check_eq("t3_full_ready", 32'(pix_ready), 32'(0));
        check_eq("t3_full_level", 32'(fifo_level), 32'(16));
        tick();
        check_eq("t2_px00", 32'({r_out, g_out, b_out}), 32'(24'h112233));
        check_eq("t3_pop_level", 32'(fifo_level), 32'(15));
        check_eq("t3_pop_ready", 32'(pix_ready), 32'(1));
        tick();
        check_eq("t2_px10", 32'({r_out, g_out, b_out}), 32'(24'h445566));
        check_eq("t2_synced", 32'(synced), 32'(1));
        check_eq("t2_uf", 32'(underflow), 32'(0));

        // Full frames at line rate
        run_cycles(3 * FRAME_CYC);
        check_eq("t6_uf", 32'(underflow), 32'(0));
        check_eq("t6_synced", 32'(synced), 32'(1));

        // Starve the stream until the FIFO runs dry mid-line
        valid_pct = 0;
        for (int n = 0; n < 2 * FRAME_CYC && !model_uf; n++) tick();
        check_eq("t4_uf", 32'(underflow), 32'(1));
        check_eq("t4_synced", 32'(synced), 32'(0));
        valid_pct = 100;
        run_cycles(3 * FRAME_CYC);
        check_eq("t4_relock", 32'(synced), 32'(1));
        check_eq("t4_sticky", 32'(underflow), 32'(1));

        // Reset mid-frame clears the sticky flag and forces a fresh lock
        for (int n = 0; n < FRAME_CYC && !(vc == 2 && hc == 10); n++) tick();
        reset = 1'b1;
        run_cycles(2);
        reset = 1'b0;
        run_cycles(3 * FRAME_CYC);
        check_eq("rst_uf_clr", 32'(underflow), 32'(0));
        check_eq("rst_relock", 32'(synced), 32'(1));

        // Marker injected mid-line gives a misalignment
        for (int n = 0; n < FRAME_CYC && !(vc == 1 && hc == 0); n++) tick();
        src_inject_sof();
        for (int n = 0; n < FRAME_CYC && phase == M_LOCK; n++) tick();
        check_eq("t5_uf", 32'(underflow), 32'(1));
        check_eq("t5_synced", 32'(synced), 32'(0));
        run_cycles(3 * FRAME_CYC);
        check_eq("t5_relock", 32'(synced), 32'(1));

        // Random rates, marker injections and occasional resets
        for (int blk = 0; blk < 40; blk++) begin
            valid_pct = int'($urandom_range(100, 55));
            if ($urandom_range(7) == 0) src_inject_sof();
            if ($urandom_range(15) == 0) begin
                reset = 1'b1;
                run_cycles(int'($urandom_range(2, 1)));
                reset = 1'b0;
            end
            run_cycles(300);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
